// File: rtl/step_sequencer.sv
// Step sequencer: turns up/down/load requests into fixed-width pulses with an
// enforced low gap, and tracks the counter value it expects those pulses to produce.
module step_sequencer #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned PULSE_CYCLES = 5,
  parameter int unsigned GAP_CYCLES   = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_up,
  input  logic             req_dn,
  input  logic             req_load,
  input  logic [WIDTH-1:0] preload,
  input  logic [WIDTH-1:0] increment,
  output logic             clk_up,
  output logic             clk_dn,
  output logic             cnt_reset,
  output logic             busy,
  output logic             overrun,
  output logic [WIDTH-1:0] shadow_count
);

  typedef enum logic [2:0] {IDLE, LOAD, UP, DN, GAP} state_t;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  state_t     state, next_state;
  logic [7:0] cnt, cnt_next;
  logic       pend_up, pend_dn, pend_load, last_dn;
  logic       start_up, start_dn, start_load;
  logic       clk_up_next, clk_dn_next, cnt_reset_next, busy_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    start_up   = 1'b0;
    start_dn   = 1'b0;
    start_load = 1'b0;
    case (state)
      IDLE: begin
        // Load beats steps; with both directions pending, alternate from the last served.
        if (pend_load) begin
          next_state = LOAD;
          cnt_next   = PULSE_LAST;
          start_load = 1'b1;
        end else if (pend_up && (!pend_dn || last_dn)) begin
          next_state = UP;
          cnt_next   = PULSE_LAST;
          start_up   = 1'b1;
        end else if (pend_dn) begin
          next_state = DN;
          cnt_next   = PULSE_LAST;
          start_dn   = 1'b1;
        end
      end
      LOAD, UP, DN: begin
        if (cnt == '0) begin
          next_state = GAP;
          cnt_next   = GAP_LAST;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == '0) next_state = IDLE;
        else           cnt_next   = cnt - 8'd1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    clk_up_next    = (next_state == UP);
    clk_dn_next    = (next_state == DN);
    cnt_reset_next = (next_state == LOAD);
    busy_next      = (next_state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_up    <= 1'b0;
      clk_dn    <= 1'b0;
      cnt_reset <= 1'b0;
      busy      <= 1'b0;
    end else begin
      clk_up    <= clk_up_next;
      clk_dn    <= clk_dn_next;
      cnt_reset <= cnt_reset_next;
      busy      <= busy_next;
    end
  end

  // A request landing on the same edge its flag is consumed re-arms the flag
  // for a further pulse rather than counting as an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_up      <= 1'b0;
      pend_dn      <= 1'b0;
      pend_load    <= 1'b0;
      last_dn      <= 1'b1;
      overrun      <= 1'b0;
      shadow_count <= '0;
    end else begin
      if (req_load) begin
        pend_load <= 1'b1;
        pend_up   <= 1'b0;
        pend_dn   <= 1'b0;
      end else begin
        if (start_load) pend_load <= 1'b0;
        if (req_up) begin
          pend_up <= 1'b1;
          if (pend_up && !start_up) overrun <= 1'b1;
        end else if (start_up) begin
          pend_up <= 1'b0;
        end
        if (req_dn) begin
          pend_dn <= 1'b1;
          if (pend_dn && !start_dn) overrun <= 1'b1;
        end else if (start_dn) begin
          pend_dn <= 1'b0;
        end
      end
      if (start_load) shadow_count <= preload;
      if (start_up) begin
        shadow_count <= shadow_count + increment;
        last_dn      <= 1'b0;
      end
      if (start_dn) begin
        shadow_count <= shadow_count - increment;
        last_dn      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed and randomized bench for step_sequencer against a timeline model
// (each operation occupies PULSE+GAP cycles, with one idle cycle before the next).
module tb_step_sequencer;

  localparam int P = 5;
  localparam int G = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_up = 1'b0, req_dn = 1'b0, req_load = 1'b0;
  logic [15:0] preload = '0, increment = '0;
  logic        clk_up, clk_dn, cnt_reset, busy, overrun;
  logic [15:0] shadow_count;

  step_sequencer #(.WIDTH(16), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset_n(reset_n), .req_up(req_up), .req_dn(req_dn),
    .req_load(req_load), .preload(preload), .increment(increment),
    .clk_up(clk_up), .clk_dn(clk_dn), .cnt_reset(cnt_reset), .busy(busy),
    .overrun(overrun), .shadow_count(shadow_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: m_kind 0 none, 1 load, 2 up, 3 down; m_left = cycles left in pulse+gap
  int m_left, m_kind, m_shadow;
  bit m_pu, m_pd, m_pl, m_last_dn, m_ovr;

  int up_rises, dn_rises, cr_hi, busy_hi, dn_hi, first_dir;
  logic prev_up, prev_dn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_kind = 0; m_shadow = 0;
    m_pu = 0; m_pd = 0; m_pl = 0; m_last_dn = 1; m_ovr = 0;
  endtask

  task automatic model_edge();
    bit st_up, st_dn, st_ld;
    st_up = 0; st_dn = 0; st_ld = 0;
    if (m_left > 0) m_left--;
    else if (m_pl) st_ld = 1;
    else if (m_pu && m_pd) begin
      if (m_last_dn) st_up = 1; else st_dn = 1;
    end
    else if (m_pu) st_up = 1;
    else if (m_pd) st_dn = 1;
    if (st_ld) begin m_kind = 1; m_left = P + G; m_shadow = preload; end
    if (st_up) begin m_kind = 2; m_left = P + G; m_shadow = (m_shadow + increment) % 65536; m_last_dn = 0; end
    if (st_dn) begin m_kind = 3; m_left = P + G; m_shadow = (m_shadow - increment + 65536) % 65536; m_last_dn = 1; end
    if (req_load) begin
      m_pl = 1; m_pu = 0; m_pd = 0;
    end else begin
      if (st_ld) m_pl = 0;
      if (req_up) begin if (m_pu && !st_up) m_ovr = 1; m_pu = 1; end
      else if (st_up) m_pu = 0;
      if (req_dn) begin if (m_pd && !st_dn) m_ovr = 1; m_pd = 1; end
      else if (st_dn) m_pd = 0;
    end
  endtask

  task automatic check_outputs();
    chk("clk_up", clk_up, (m_kind == 2 && m_left > G));
    chk("clk_dn", clk_dn, (m_kind == 3 && m_left > G));
    chk("cnt_reset", cnt_reset, (m_kind == 1 && m_left > G));
    chk("busy", busy, (m_left > 0));
    chk("overrun", overrun, m_ovr);
    chk("shadow_count", shadow_count, m_shadow);
    chk("one_hot_pulse", 32'(clk_up) + 32'(clk_dn) + 32'(cnt_reset) <= 1, 1);
  endtask

  task automatic clear_tallies();
    up_rises = 0; dn_rises = 0; cr_hi = 0; busy_hi = 0; dn_hi = 0; first_dir = 0;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!reset_n) model_reset(); else model_edge();
      #1;
      check_outputs();
      if (clk_up && !prev_up) begin up_rises++; if (first_dir == 0) first_dir = 1; end
      if (clk_dn && !prev_dn) begin dn_rises++; if (first_dir == 0) first_dir = 2; end
      if (cnt_reset) cr_hi++;
      if (busy) busy_hi++;
      if (clk_dn) dn_hi++;
      prev_up = clk_up;
      prev_dn = clk_dn;
    end
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    prev_up = 0; prev_dn = 0;
    check_outputs();
    cyc(2);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    prev_up = 0; prev_dn = 0;
    clear_tallies();
    do_reset();

    // load
    preload = 16'd1000;
    clear_tallies();
    req_load = 1; cyc(1); req_load = 0;
    cyc(20);
    chk("load_cnt_reset_cycles", cr_hi, 5);
    chk("load_busy_cycles", busy_hi, 15);
    chk("load_shadow", shadow_count, 1000);

    // up then down, with the two-edge latency
    increment = 16'd25;
    req_up = 1; cyc(1); req_up = 0;
    chk("latency_before", clk_up, 0);
    cyc(1);
    chk("latency_pulse", clk_up, 1);
    cyc(16);
    chk("up_shadow", shadow_count, 1025);
    clear_tallies();
    req_dn = 1; cyc(1); req_dn = 0;
    cyc(18);
    chk("dn_shadow", shadow_count, 1000);
    chk("dn_high_cycles", dn_hi, 5);

    // simultaneous request after reset: up served first
    do_reset();
    clear_tallies();
    req_up = 1; req_dn = 1; cyc(1); req_up = 0; req_dn = 0;
    cyc(40);
    chk("simul_first_dir", first_dir, 1);
    chk("simul_up_rises", up_rises, 1);
    chk("simul_dn_rises", dn_rises, 1);
    chk("simul_shadow", shadow_count, 0);

    // merge during a pulse, then load beating a step request
    clear_tallies();
    req_up = 1; cyc(1); req_up = 0;
    cyc(2);
    req_up = 1; cyc(1); req_up = 0;
    cyc(1);
    req_up = 1; cyc(1); req_up = 0;
    cyc(40);
    chk("merge_overrun", overrun, 1);
    chk("merge_up_rises", up_rises, 2);
    clear_tallies();
    preload = 16'd777;
    req_load = 1; req_up = 1; cyc(1); req_load = 0; req_up = 0;
    cyc(20);
    chk("prio_cnt_reset_cycles", cr_hi, 5);
    chk("prio_up_rises", up_rises, 0);
    chk("prio_shadow", shadow_count, 777);

    // wrap below zero
    do_reset();
    increment = 16'd25;
    req_dn = 1; cyc(1); req_dn = 0;
    cyc(20);
    chk("wrap_shadow", shadow_count, 65511);

    // reset during the second cycle of clk_up
    req_up = 1; cyc(1); req_up = 0;
    cyc(2);
    chk("midreset_pulse_on", clk_up, 1);
    clear_tallies();
    do_reset();
    chk("midreset_clk_up", clk_up, 0);
    chk("midreset_busy", busy, 0);
    cyc(30);
    chk("midreset_no_pulse", up_rises + dn_rises + cr_hi, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_up   = ($urandom_range(0, 9) == 0);
      req_dn   = ($urandom_range(0, 9) == 0);
      req_load = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) preload = 16'($urandom);
      if ($urandom_range(0, 19) == 0) increment = 16'($urandom);
      if (i == 300) begin
        req_up = 0; req_dn = 0; req_load = 0;
        do_reset();
      end else begin
        cyc(1);
      end
    end
    req_up = 0; req_dn = 0; req_load = 0;
    cyc(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
